// File: rtl/align_wavefront_ctrl.sv
// align_wavefront_ctrl: job sequencer for the local-alignment array.
// Walks LOAD -> CALC -> DRAIN -> TRACE for one query/database pair.
// Query/database lengths are given at runtime in PU tiles. Abort, timeout and
// the start/ready/done handshake wrap the sequence. All outputs are decoded from
// registered state, except the traceback address split (rd_*), which is purely
// combinational.
module align_wavefront_ctrl #(
    parameter  int unsigned SEQ_LEN    = 32,
    parameter  int unsigned PE_DIM     = 2,
    parameter  int unsigned LOAD_BEATS = 8,
    parameter  int unsigned CALC_LAT   = 1,
    parameter  int unsigned TB_MAX     = 256,
    localparam int unsigned NUM_PU     = SEQ_LEN / PE_DIM,
    localparam int unsigned ND         = 2 * NUM_PU - 1,
    localparam int unsigned LEN_W      = $clog2(NUM_PU + 1),
    localparam int unsigned DIAG_W     = $clog2(ND),
    localparam int unsigned PU_W       = $clog2(NUM_PU),
    localparam int unsigned POS_W      = $clog2(SEQ_LEN),
    localparam int unsigned PE_SH      = $clog2(PE_DIM),
    localparam int unsigned BI_W       = $clog2(LOAD_BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len_q,
    input  logic [LEN_W-1:0]     len_d,
    input  logic                 abort,
    output logic                 ready,
    output logic                 cfg_err,
    output logic                 buf_wr_en,
    output logic [BI_W-1:0]      buf_idx,
    output logic                 calc_valid,
    output logic [DIAG_W-1:0]    calc_diag,
    output logic [NUM_PU-1:0]    pu_mask,
    output logic                 mem_wr_en,
    output logic [DIAG_W-1:0]    mem_wr_diag,
    output logic                 max_wr_en,
    output logic                 tb_en,
    output logic                 tb_start,
    input  logic [POS_W-1:0]     tb_row,
    input  logic [POS_W-1:0]     tb_col,
    input  logic                 tb_finished,
    output logic [DIAG_W-1:0]    rd_diag,
    output logic [PU_W-1:0]      rd_pu,
    output logic [2*PE_SH-1:0]   rd_pe,
    output logic                 done,
    output logic                 tb_timeout,
    output logic                 aborted
);

    // One shared counter serves load beats, diagonals, drain and traceback
    // cycles, so it must be wide enough for the largest of them.
    localparam int unsigned TBC_W = $clog2(TB_MAX);
    localparam int unsigned DRC_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam int unsigned CW0   = (BI_W > DIAG_W) ? BI_W : DIAG_W;
    localparam int unsigned CW1   = (CW0 > TBC_W) ? CW0 : TBC_W;
    localparam int unsigned CNT_W = (CW1 > DRC_W) ? CW1 : DRC_W;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_BEATS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(CALC_LAT - 1);
    localparam logic [CNT_W-1:0] TB_LAST    = CNT_W'(TB_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_TRACE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   lq_q, lq_d;
    logic [LEN_W-1:0]   ld_q, ld_d;
    logic               cfg_err_q, cfg_err_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               aborted_q, aborted_d;

    logic [CALC_LAT-1:0] vld_q, vld_d;
    logic [DIAG_W-1:0]   pdiag_q [CALC_LAT];
    logic [DIAG_W-1:0]   pdiag_d [CALC_LAT];

    logic               pipe_clr;
    logic               len_ok;
    logic [LEN_W:0]     diag_span;
    logic [CNT_W-1:0]   calc_last;
    logic [NUM_PU-1:0]  mask_c;

    // Lengths are legal when both lie in 1..NUM_PU; the last diagonal index is Lq+Ld-2.
    always_comb begin
        len_ok    = (len_q != '0) && (32'(len_q) <= NUM_PU)
                 && (len_d != '0) && (32'(len_d) <= NUM_PU);
        diag_span = {1'b0, lq_q} + {1'b0, ld_q} - (LEN_W + 1)'(2);
        calc_last = CNT_W'(diag_span);
    end

    // State registers and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lq_q      <= '0;
            ld_q      <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lq_q      <= lq_d;
            ld_q      <= ld_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic; abort outranks every normal phase exit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lq_d      = lq_q;
        ld_d      = ld_q;
        cfg_err_d = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        aborted_d = 1'b0;
        pipe_clr  = 1'b0;

        if ((state_q != S_IDLE) && abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
            pipe_clr  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        if (len_ok) begin
                            lq_d    = len_q;
                            ld_d    = len_d;
                            state_d = S_LOAD;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    if (cnt_q == calc_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_TRACE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_TRACE: begin
                    if (tb_finished) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else if (cnt_q == TB_LAST) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // PU j works on tile (cnt-j, j) when that tile lies inside the Lq x Ld grid.
    always_comb begin
        mask_c = '0;
        if (state_q == S_CALC) begin
            for (int unsigned j = 0; j < NUM_PU; j++) begin
                mask_c[j] = (j < 32'(ld_q)) && (32'(cnt_q) >= j)
                         && ((32'(cnt_q) - j) < 32'(lq_q));
            end
        end
    end

    // Shift calc_valid/calc_diag through the compute-latency pipe; abort flushes it.
    always_comb begin
        vld_d[0]   = calc_valid;
        pdiag_d[0] = calc_diag;
        for (int unsigned i = 1; i < CALC_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            pdiag_d[i] = pdiag_q[i-1];
        end
        if (pipe_clr) begin
            vld_d = '0;
            for (int unsigned i = 0; i < CALC_LAT; i++) begin
                pdiag_d[i] = '0;
            end
        end
    end

    // Compute-latency pipe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < CALC_LAT; i++) begin
                pdiag_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            pdiag_q <= pdiag_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign cfg_err     = cfg_err_q;
    assign buf_wr_en   = (state_q == S_LOAD);
    assign buf_idx     = (state_q == S_LOAD) ? cnt_q[BI_W-1:0] : '0;
    assign calc_valid  = (state_q == S_CALC);
    assign calc_diag   = (state_q == S_CALC) ? cnt_q[DIAG_W-1:0] : '0;
    assign pu_mask     = mask_c;
    assign mem_wr_en   = vld_q[CALC_LAT-1];
    assign mem_wr_diag = pdiag_q[CALC_LAT-1];
    assign max_wr_en   = vld_q[CALC_LAT-1];
    assign tb_en       = (state_q == S_TRACE);
    assign tb_start    = (state_q == S_TRACE) && (cnt_q == '0);
    assign done        = done_q;
    assign tb_timeout  = timeout_q;
    assign aborted     = aborted_q;

    assign rd_diag = DIAG_W'(tb_row[POS_W-1:PE_SH]) + DIAG_W'(tb_col[POS_W-1:PE_SH]);
    assign rd_pu   = tb_col[POS_W-1:PE_SH];
    assign rd_pe   = {tb_row[PE_SH-1:0], tb_col[PE_SH-1:0]};

endmodule

// File: tb/tb_align_wavefront_ctrl.sv
// Bench for align_wavefront_ctrl: directed and random jobs against a timeline model.
module tb_align_wavefront_ctrl;

    localparam int LB  = 8;    // load beats
    localparam int CL  = 1;    // compute latency
    localparam int TBM = 256;  // traceback limit

    logic        clk = 1'b0;
    logic        rst, start, abort, tb_finished;
    logic [4:0]  len_q, len_d, tb_row, tb_col;
    logic        ready, cfg_err, buf_wr_en, calc_valid, mem_wr_en, max_wr_en;
    logic        tb_en, tb_start, done, tb_timeout, aborted;
    logic [2:0]  buf_idx;
    logic [4:0]  calc_diag, mem_wr_diag, rd_diag;
    logic [15:0] pu_mask;
    logic [3:0]  rd_pu;
    logic [1:0]  rd_pe;
    logic [39:0] obs;

    int checks = 0;
    int errors = 0;
    int jobn   = 0;

    always #5 clk = ~clk;

    align_wavefront_ctrl #(
        .SEQ_LEN(32), .PE_DIM(2), .LOAD_BEATS(8), .CALC_LAT(1), .TB_MAX(256)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len_q(len_q), .len_d(len_d),
        .abort(abort), .ready(ready), .cfg_err(cfg_err), .buf_wr_en(buf_wr_en),
        .buf_idx(buf_idx), .calc_valid(calc_valid), .calc_diag(calc_diag),
        .pu_mask(pu_mask), .mem_wr_en(mem_wr_en), .mem_wr_diag(mem_wr_diag),
        .max_wr_en(max_wr_en), .tb_en(tb_en), .tb_start(tb_start),
        .tb_row(tb_row), .tb_col(tb_col), .tb_finished(tb_finished),
        .rd_diag(rd_diag), .rd_pu(rd_pu), .rd_pe(rd_pe), .done(done),
        .tb_timeout(tb_timeout), .aborted(aborted)
    );

    assign obs = {ready, cfg_err, buf_wr_en, buf_idx, calc_valid, calc_diag, pu_mask,
                  mem_wr_en, mem_wr_diag, max_wr_en, tb_en, tb_start, done, tb_timeout, aborted};

    function automatic logic [39:0] pack(logic r, logic c, logic bw, logic [2:0] bi,
                                         logic cv, logic [4:0] cd, logic [15:0] m,
                                         logic mw, logic [4:0] md, logic te, logic ts,
                                         logic dn, logic to, logic ab);
        return {r, c, bw, bi, cv, cd, m, mw, md, mw, te, ts, dn, to, ab};
    endfunction

    localparam logic [39:0] IDLE_V = {1'b1, 39'd0};

    // Tile (i,j) sits on anti-diagonal i+j; PU j scores column j of the grid.
    function automatic logic [15:0] exp_mask(int lq, int ld, int d);
        logic [15:0] m = '0;
        for (int i = 0; i < lq; i++)
            for (int j = 0; j < ld; j++)
                if (i + j == d) m[j] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [39:0] o, input logic [39:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        step();
        chk(tag, obs, IDLE_V);
    endtask

    task automatic rd_chk(input int row, input int col);
        logic [10:0] x;
        tb_row = 5'(row);
        tb_col = 5'(col);
        #1;
        x = {5'(row / 2 + col / 2), 4'(col / 2), 1'(row % 2), 1'(col % 2)};
        chk($sformatf("rd_r%0d_c%0d", row, col), 40'({rd_diag, rd_pu, rd_pe}), 40'(x));
    endtask

    // Run one job from acceptance to its end cycle. fin: TRACE cycle that raises
    // tb_finished (-1 none); ab/rs: job cycle that raises abort/rst (-1 none).
    // Returns right after checking the end cycle, so a following job call is back-to-back.
    task automatic job(input int lq, input int ld, input int fin, input int ab, input int rs);
        int n, ts, e, kind;
        logic r, bw, cv, mw, te, tsb, dn, to, abp;
        logic [2:0]  bi;
        logic [4:0]  cd, md;
        logic [15:0] m;
        jobn++;
        n  = lq + ld - 1;
        ts = LB + n + CL;
        if (fin >= 0 && fin < TBM) begin e = ts + fin + 1; kind = 0; end
        else begin e = ts + TBM; kind = 1; end
        if (ab >= 0 && ab < e) begin e = ab + 1; kind = 2; end
        if (rs >= 0 && rs < e) begin e = rs + 1; kind = 3; end
        len_q = 5'(lq);
        len_d = 5'(ld);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= e; t++) begin
            {r, bw, cv, mw, te, tsb, dn, to, abp} = '0;
            bi = '0; cd = '0; md = '0; m = '0;
            if (t == e) begin
                r = 1'b1; dn = (kind == 0); to = (kind == 1); abp = (kind == 2);
            end else begin
                if (t < LB) begin bw = 1'b1; bi = 3'(t); end
                else if (t < LB + n) begin cv = 1'b1; cd = 5'(t - LB); m = exp_mask(lq, ld, t - LB); end
                else if (t >= ts) begin te = 1'b1; tsb = (t == ts); end
                if (t >= LB + CL && t < LB + CL + n) begin mw = 1'b1; md = 5'(t - LB - CL); end
            end
            chk($sformatf("job%0d_%0dx%0d_t%0d", jobn, lq, ld, t), obs,
                pack(r, 1'b0, bw, bi, cv, cd, m, mw, md, te, tsb, dn, to, abp));
            if (t < e) begin
                tb_finished = (fin >= 0) && (t == ts + fin);
                abort       = (t == ab);
                rst         = (t == rs);
                start       = (t == 2);
                step();
            end else begin
                {tb_finished, abort, rst, start} = '0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lq, ld, fin, ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tb_finished = 1'b0;
        len_q = '0; len_d = '0; tb_row = '0; tb_col = '0;
        step();
        step();
        chk("reset", obs, IDLE_V);
        rst = 1'b0;

        rd_chk(5, 6);
        for (int k = 0; k < 6; k++) rd_chk(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));

        idle_chk("idle0");
        job(16, 16, 3, -1, -1);
        job(3, 5, 0, -1, -1);          // back-to-back on the done pulse cycle
        idle_chk("idle1");

        len_q = 5'd0; len_d = 5'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_err_lenq0", obs, {2'b11, 38'd0});
        idle_chk("cfg_err_lenq0_after");
        len_q = 5'd4; len_d = 5'd17; start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_err_lend17", obs, {2'b11, 38'd0});
        idle_chk("cfg_err_lend17_after");

        abort = 1'b1;
        idle_chk("abort_in_idle");
        abort = 1'b0;

        job(16, 16, -1, LB + 4, -1);   // abort while scoring diagonal 4
        idle_chk("after_abort");
        job(4, 4, -1, -1, -1);         // traceback timeout
        idle_chk("after_timeout");
        job(2, 3, TBM - 1, -1, -1);    // finish on the timeout cycle counts as done
        job(2, 2, -1, -1, LB + 3 + CL + 5);  // rst during TRACE
        idle_chk("after_rst");

        for (int k = 0; k < 10; k++) begin
            lq  = int'($urandom_range(1, 16));
            ld  = int'($urandom_range(1, 16));
            fin = int'($urandom_range(0, 30));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12 + lq + ld)) : -1;
            job(lq, ld, fin, ab, -1);
            if ($urandom_range(0, 1) == 1) idle_chk("idle_rand");
        end
        idle_chk("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
